// File: rtl/ram_access_ctrl_if.sv
// Purpose: request/response and debug signals between the coherence controller and main memory.
// Latency: none (plain signal bundle).
// Backpressure: ramstate tells the requester when its held request has completed.
//
// Ports (signals):
//   ramREN/ramWEN/ramaddr/ramstore : level request from the controller, held until ACCESS
//   ramload/ramstate               : read data and FREE/BUSY/ACCESS/ERROR handshake
//   dbgWEN/dbgaddr/dbgstore        : debug write port (preload)
//   dbgload                        : debug combinational read (dump)
interface ram_access_ctrl_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        dbgWEN;
  logic [31:0] dbgaddr;
  logic [31:0] dbgstore;
  logic [31:0] dbgload;

  // Requester side (controller / testbench).
  modport master (
    output ramREN, ramWEN, ramaddr, ramstore, dbgWEN, dbgaddr, dbgstore,
    input  ramload, ramstate, dbgload
  );

  // Memory side.
  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore, dbgWEN, dbgaddr, dbgstore,
    output ramload, ramstate, dbgload
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Purpose: word-addressed main-memory model behind the coherence controller, with a debug port.
// Latency: request in cycle t -> BUSY in t+1..t+LAT, ACCESS (data/commit) in t+LAT+1.
// Backpressure: requester holds its level request until ramstate shows ACCESS; a changed request restarts.
//
// Ports:
//   CLK  : clock, all state on the rising edge
//   RST  : asynchronous active-high reset (memory contents are kept)
//   bus  : ram_access_ctrl_if.slave (ram request/response + debug port)
module ram_access_ctrl #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  ram_access_ctrl_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned RELOAD = (LAT > 0) ? LAT - 1 : 0;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RELOAD);

  // Encoding is the ramstate value itself, so the output is a plain register.
  typedef enum logic [1:0] {
    S_FREE   = 2'b00,
    S_BUSY   = 2'b01,
    S_ACCESS = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Latched request (word address only; byte offset is ignored).
  logic          r_ren;
  logic          r_wen;
  logic [29:0]   r_addr;
  logic [31:0]   r_store;
  logic [31:0]   r_ramload;

  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_oor;
  logic          w_illegal;
  logic          w_diff;
  logic          w_latch;
  logic          w_use_live;
  logic          w_commit_wr;
  logic          w_commit_rd;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_dbg_idx;
  logic [31:0]   w_commit_dat;
  logic          w_unused;

  assign w_req     = bus.ramREN | bus.ramWEN;
  assign w_oor     = |(bus.ramaddr >> (2 + AW));
  assign w_illegal = (bus.ramREN & bus.ramWEN) | (w_req & w_oor);

  // Store data only matters for a write; a read ignores ramstore changes.
  assign w_diff = (bus.ramREN != r_ren) || (bus.ramWEN != r_wen) ||
                  (bus.ramaddr[31:2] != r_addr) ||
                  (bus.ramWEN && (bus.ramstore != r_store));

  assign w_dbg_idx = bus.dbgaddr[2 +: AW];

  // With LAT=0 the access completes on the same edge that accepts it, so
  // the commit must use the live request rather than the (not yet written) latch.
  assign w_idx        = w_use_live ? bus.ramaddr[2 +: AW] : r_addr[AW-1:0];
  assign w_commit_dat = w_use_live ? bus.ramstore : r_store;

  assign w_unused = ^{bus.ramaddr[1:0], bus.dbgaddr[1:0], bus.dbgaddr[31:2+AW]};

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_latch     = 1'b0;
    w_use_live  = 1'b0;
    w_commit_wr = 1'b0;
    w_commit_rd = 1'b0;
    case (r_state)
      S_BUSY: begin
        if (!w_req) begin
          w_next = S_FREE;
        end else if (w_diff) begin
          if (w_illegal) begin
            w_next = S_ERROR;
          end else begin
            w_latch    = 1'b1;
            w_next     = S_BUSY;
            w_cnt_next = CNT_RELOAD;
          end
        end else if (r_cnt == '0) begin
          w_next      = S_ACCESS;
          w_commit_wr = r_wen;
          w_commit_rd = r_ren;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      // FREE, ACCESS and ERROR all evaluate the request as a fresh one.
      default: begin
        if (!w_req) begin
          w_next = S_FREE;
        end else if (w_illegal) begin
          w_next = S_ERROR;
        end else begin
          w_latch = 1'b1;
          if (LAT == 0) begin
            w_next      = S_ACCESS;
            w_use_live  = 1'b1;
            w_commit_wr = bus.ramWEN;
            w_commit_rd = bus.ramREN;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = CNT_RELOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_ramload <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_ren   <= bus.ramREN;
        r_wen   <= bus.ramWEN;
        r_addr  <= bus.ramaddr[31:2];
        r_store <= bus.ramstore;
      end
      if (w_commit_rd) begin
        r_ramload <= r_mem[w_idx];
      end
    end
  end

  // Memory is never reset. A reset on the commit edge cancels the write.
  // The debug write is last so it wins a same-word collision.
  always_ff @(posedge CLK) begin
    if (w_commit_wr && !RST) begin
      r_mem[w_idx] <= w_commit_dat;
    end
    if (bus.dbgWEN) begin
      r_mem[w_dbg_idx] <= bus.dbgstore;
    end
  end

  assign bus.ramstate = r_state;
  assign bus.ramload  = r_ramload;
  assign bus.dbgload  = r_mem[w_dbg_idx];

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Purpose: self-checking bench for ram_access_ctrl, LAT=0 and LAT=2 instances driven in lockstep.
// Latency: checks every cycle on the falling edge against a transaction-level memory model.
// Backpressure: stimulus holds or changes level requests freely; the model decides completion.
module tb_ram_access_ctrl;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] BS = 2'd1;
  localparam logic [1:0] AC = 2'd2;
  localparam logic [1:0] ER = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst = 1'b0;
  logic        t_ren = 1'b0;
  logic        t_wen = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_store = '0;
  logic        t_dwen = 1'b0;
  logic [31:0] t_daddr = '0;
  logic [31:0] t_dstore = '0;

  ram_access_ctrl_if bus0 ();
  ram_access_ctrl_if bus2 ();

  assign bus0.ramREN   = t_ren;
  assign bus0.ramWEN   = t_wen;
  assign bus0.ramaddr  = t_addr;
  assign bus0.ramstore = t_store;
  assign bus0.dbgWEN   = t_dwen;
  assign bus0.dbgaddr  = t_daddr;
  assign bus0.dbgstore = t_dstore;
  assign bus2.ramREN   = t_ren;
  assign bus2.ramWEN   = t_wen;
  assign bus2.ramaddr  = t_addr;
  assign bus2.ramstore = t_store;
  assign bus2.dbgWEN   = t_dwen;
  assign bus2.dbgaddr  = t_daddr;
  assign bus2.dbgstore = t_dstore;

  ram_access_ctrl #(.LAT(0), .DEPTH(1024)) dut0 (.CLK(clk), .RST(t_rst), .bus(bus0));
  ram_access_ctrl #(.LAT(2), .DEPTH(1024)) dut2 (.CLK(clk), .RST(t_rst), .bus(bus2));

  int n_vec = 0;
  int n_bad = 0;

  // Model, index 0 -> LAT=0 instance, index 1 -> LAT=2 instance.
  logic [1:0]  m_st   [2];
  int          m_wait [2];  // BUSY cycles spent on the current request
  bit          m_ren  [2];
  bit          m_wen  [2];
  logic [29:0] m_wa   [2];
  logic [31:0] m_sd   [2];
  logic [31:0] m_load [2];
  logic [31:0] m_mem  [2][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k]   = FR;
    m_wait[k] = 0;
    m_ren[k]  = 1'b0;
    m_wen[k]  = 1'b0;
    m_load[k] = '0;
  endtask

  task automatic model_fire(input int k);
    int idx;
    idx = int'(t_addr[11:2]);
    if (t_wen) m_mem[k][idx] = t_store;
    else       m_load[k]     = m_mem[k][idx];
    m_st[k] = AC;
  endtask

  // One clock edge as seen at transaction level.
  task automatic model_edge(input int k);
    int lat;
    bit req, legal, same;
    lat   = (k == 0) ? 0 : 2;
    req   = t_ren | t_wen;
    legal = !(t_ren && t_wen) && (t_addr[31:12] == 20'd0);
    same  = (m_st[k] == BS) && (t_ren == m_ren[k]) && (t_wen == m_wen[k]) &&
            (t_addr[31:2] == m_wa[k]) && (!t_wen || (t_store == m_sd[k]));
    if (!t_rst) begin
      if (!req) begin
        m_st[k] = FR;
      end else if (same) begin
        if (m_wait[k] == lat) model_fire(k);
        else m_wait[k]++;
      end else if (!legal) begin
        m_st[k] = ER;
      end else begin
        m_ren[k] = t_ren;
        m_wen[k] = t_wen;
        m_wa[k]  = t_addr[31:2];
        m_sd[k]  = t_store;
        if (lat == 0) begin
          model_fire(k);
        end else begin
          m_st[k]   = BS;
          m_wait[k] = 1;
        end
      end
    end
    if (t_dwen) m_mem[k][int'(t_daddr[11:2])] = t_dstore;
  endtask

  task automatic sample_check();
    logic [31:0] d0, d2;
    @(negedge clk);
    if (t_rst) begin
      model_reset(0);
      model_reset(1);
    end
    chk("state_lat0", 32'(bus0.ramstate), 32'(m_st[0]));
    chk("state_lat2", 32'(bus2.ramstate), 32'(m_st[1]));
    chk("load_lat0", bus0.ramload, m_load[0]);
    chk("load_lat2", bus2.ramload, m_load[1]);
    d0 = m_mem[0][int'(t_daddr[11:2])];
    d2 = m_mem[1][int'(t_daddr[11:2])];
    if (!$isunknown(d0)) chk("dbgload_lat0", bus0.dbgload, d0);
    if (!$isunknown(d2)) chk("dbgload_lat2", bus2.dbgload, d2);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic drive(input bit rst, input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] store, input bit dwen, input logic [31:0] daddr,
                       input logic [31:0] dstore);
    t_rst = rst; t_ren = ren; t_wen = wen; t_addr = addr; t_store = store;
    t_dwen = dwen; t_daddr = daddr; t_dstore = dstore;
  endtask

  typedef struct {
    bit          rst, ren, wen;
    logic [31:0] addr, store;
    bit          dwen;
    logic [31:0] daddr, dstore;
    logic [1:0]  st;     // expected LAT=2 ramstate during this cycle
    bit          cl;     // check ramload
    logic [31:0] ld;
    bit          cd;     // check dbgload
    logic [31:0] dl;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(bit rst, bit ren, bit wen, logic [31:0] addr, logic [31:0] store,
                              bit dwen, logic [31:0] daddr, logic [31:0] dstore, logic [1:0] st,
                              bit cl, logic [31:0] ld, bit cd, logic [31:0] dl);
    vec_t v;
    v.rst = rst; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.dwen = dwen; v.daddr = daddr; v.dstore = dstore; v.st = st;
    v.cl = cl; v.ld = ld; v.cd = cd; v.dl = dl;
    tbl.push_back(v);
  endfunction

  task automatic random_phase(input int n);
    int op;
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        op    = int'($urandom_range(0, 15));
        t_ren = (op < 6) || (op == 15);
        t_wen = ((op >= 6) && (op < 12)) || (op == 15);
        t_addr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) t_addr = t_addr | (32'h1 << $urandom_range(12, 31));
        t_store = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        t_store = $urandom;
      end
      t_dwen   = ($urandom_range(0, 7) == 0);
      t_daddr  = $urandom_range(0, 255);
      t_dstore = $urandom;
      t_rst    = ($urandom_range(0, 299) == 0);
      sample_check();
      advance();
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset state.
    #1 t_rst = 1'b1;
    @(negedge clk);
    chk("reset_state_lat0", 32'(bus0.ramstate), 32'(FR));
    chk("reset_state_lat2", 32'(bus2.ramstate), 32'(FR));
    chk("reset_load_lat0", bus0.ramload, 32'h0);
    chk("reset_load_lat2", bus2.ramload, 32'h0);
    @(posedge clk);
    #1 t_rst = 1'b0;

    // Preload words 0..63 with A500_00ii through the debug port.
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'(i * 4), 32'hA500_0000 | 32'(i));
      sample_check();
      advance();
    end

    // Directed sequences; expected values are for the LAT=2 instance.
    //   rst ren wen addr         store         dwen daddr    dstore        st  cl ld            cd dl
    row(0, 0, 0, 32'h40, 32'h0,         1, 32'h40, 32'hDEADBEEF, FR, 1, 32'h0,        1, 32'hA500_0010);
    row(0, 1, 0, 32'h40, 32'h0,         0, 32'h40, 32'h0,        FR, 1, 32'h0,        1, 32'hDEADBEEF);
    row(0, 1, 0, 32'h40, 32'h0,         0, 32'h40, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 1, 0, 32'h40, 32'h0,         0, 32'h40, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 0, 0, 32'h40, 32'h0,         0, 32'h40, 32'h0,        AC, 1, 32'hDEADBEEF, 0, 32'h0);
    row(0, 0, 0, 32'h40, 32'h0,         0, 32'h40, 32'h0,        FR, 1, 32'hDEADBEEF, 0, 32'h0);
    // write 0x80
    row(0, 0, 1, 32'h80, 32'h12345678,  0, 32'h80, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0020);
    row(0, 0, 1, 32'h80, 32'h12345678,  0, 32'h80, 32'h0,        BS, 0, 32'h0,        1, 32'hA500_0020);
    row(0, 0, 1, 32'h80, 32'h12345678,  0, 32'h80, 32'h0,        BS, 0, 32'h0,        1, 32'hA500_0020);
    row(0, 0, 0, 32'h80, 32'h12345678,  0, 32'h80, 32'h0,        AC, 1, 32'hDEADBEEF, 1, 32'h12345678);
    row(0, 0, 0, 32'h80, 32'h0,         0, 32'h80, 32'h0,        FR, 0, 32'h0,        1, 32'h12345678);
    // restart: address switch seen in the first BUSY cycle pushes ACCESS to cycle 4
    row(0, 1, 0, 32'h40, 32'h0,         0, 32'h44, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0011);
    row(0, 1, 0, 32'h44, 32'h0,         0, 32'h44, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 1, 0, 32'h44, 32'h0,         0, 32'h44, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 1, 0, 32'h44, 32'h0,         0, 32'h44, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 0, 0, 32'h44, 32'h0,         0, 32'h44, 32'h0,        AC, 1, 32'hA500_0011, 0, 32'h0);
    row(0, 0, 0, 32'h44, 32'h0,         0, 32'h44, 32'h0,        FR, 1, 32'hA500_0011, 0, 32'h0);
    // illegal: REN&WEN, then out of range
    row(0, 1, 1, 32'h10, 32'h77777777,  0, 32'h10, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0004);
    row(0, 0, 0, 32'h10, 32'h0,         0, 32'h10, 32'h0,        ER, 1, 32'hA500_0011, 1, 32'hA500_0004);
    row(0, 0, 0, 32'h10, 32'h0,         0, 32'h10, 32'h0,        FR, 1, 32'hA500_0011, 1, 32'hA500_0004);
    row(0, 0, 1, 32'h1000, 32'h66666666, 0, 32'h0, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0000);
    row(0, 0, 0, 32'h1000, 32'h0,       0, 32'h0,  32'h0,        ER, 1, 32'hA500_0011, 1, 32'hA500_0000);
    row(0, 0, 0, 32'h0,  32'h0,         0, 32'h0,  32'h0,        FR, 0, 32'h0,        1, 32'hA500_0000);
    // reset mid-BUSY
    row(0, 0, 1, 32'h20, 32'hAAAA5555,  0, 32'h20, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0008);
    row(0, 0, 1, 32'h20, 32'hAAAA5555,  0, 32'h20, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(1, 0, 1, 32'h20, 32'hAAAA5555,  0, 32'h20, 32'h0,        FR, 1, 32'h0,        0, 32'h0);
    row(0, 0, 0, 32'h20, 32'h0,         0, 32'h20, 32'h0,        FR, 1, 32'h0,        1, 32'hA500_0008);
    // debug write collides with the ram write commit: debug data wins
    row(0, 0, 1, 32'h0C, 32'h11111111,  0, 32'h0C, 32'h0,        FR, 0, 32'h0,        1, 32'hA500_0003);
    row(0, 0, 1, 32'h0C, 32'h11111111,  0, 32'h0C, 32'h0,        BS, 0, 32'h0,        0, 32'h0);
    row(0, 0, 1, 32'h0C, 32'h11111111,  1, 32'h0C, 32'h22222222, BS, 0, 32'h0,        1, 32'hA500_0003);
    row(0, 0, 0, 32'h0C, 32'h0,         0, 32'h0C, 32'h0,        AC, 1, 32'h0,        1, 32'h22222222);
    row(0, 0, 0, 32'h0C, 32'h0,         0, 32'h0C, 32'h0,        FR, 0, 32'h0,        1, 32'h22222222);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store,
            tbl[i].dwen, tbl[i].daddr, tbl[i].dstore);
      sample_check();
      chk($sformatf("tbl%0d_state", i), 32'(bus2.ramstate), 32'(tbl[i].st));
      if (tbl[i].cl) chk($sformatf("tbl%0d_load", i), bus2.ramload, tbl[i].ld);
      if (tbl[i].cd) chk($sformatf("tbl%0d_dbg", i), bus2.dbgload, tbl[i].dl);
      advance();
    end

    // LAT=0: held read completes every cycle.
    drive(0, 0, 0, 32'h40, 0, 1, 32'h40, 32'hCAFEF00D);
    sample_check();
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 0, 32'h40, 0, 0, 32'h40, 0);
      sample_check();
      chk($sformatf("lat0_held_state%0d", c), 32'(bus0.ramstate), (c == 0) ? 32'(FR) : 32'(AC));
      if (c > 0) chk($sformatf("lat0_held_load%0d", c), bus0.ramload, 32'hCAFEF00D);
      advance();
    end
    // LAT=0: debug and ram write on the same word and edge.
    drive(0, 0, 1, 32'h48, 32'h0BAD0BAD, 1, 32'h48, 32'h600D600D);
    sample_check();
    advance();
    drive(0, 0, 0, 32'h48, 0, 0, 32'h48, 0);
    sample_check();
    chk("lat0_collide_state", 32'(bus0.ramstate), 32'(AC));
    chk("lat0_collide_dbg", bus0.dbgload, 32'h600D600D);
    advance();

    random_phase(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
